strip_frame_sequencer: RTL
==========================

// Module: strip_frame_sequencer
// PURPOSE
//   Upstream feeder for the 1-to-4 strip channel demux. Accepts one frame of pixel bytes over a valid/ready stream.
//   Drives the demux select and data lines, sending BYTES_PER_CHANNEL bytes to each of 4 channels in order 0..3.
//   Then asserts a latch pulse so every strip updates together, and reports frame completion.
// PARAMETERS
//   IO_WIDTH           8    width of pixel byte path (matches demux data width)
//   BYTES_PER_CHANNEL  16   bytes sent per channel per frame, >=1
//   LATCH_CYCLES       4    length of latch pulse in clocks, >=1
//   UNDERRUN_LIMIT     64   idle-input cycles tolerated mid-frame (used only when SEQ_UNDERRUN_DETECT_EN is defined)
// PORTS
//   clk          in   1         system clock, rising edge
//   reset        in   1         asynchronous, active-high reset
//   frame_start  in   1         pulse; starts a frame when in IDLE
//   in_data      in   IO_WIDTH  pixel byte from frame source
//   in_valid     in   1         in_data valid
//   in_ready     out  1         sequencer accepts in_data this cycle
//   mux_select   out  2         channel select to demux
//   mux_data     out  IO_WIDTH  byte to demux
//   mux_strobe   out  1         1-cycle pulse; mux_select/mux_data valid
//   latch        out  1         strip latch, high LATCH_CYCLES cycles
//   busy         out  1         high in any state other than IDLE
//   frame_done   out  1         1-cycle pulse at frame end
//   underrun_err out  1         1-cycle pulse on underrun abort
// BEHAVIOUR
//   - Reset (async, any state): state=IDLE; all outputs 0; channel and byte counters 0.
//   - FSM states: IDLE -> STREAM -> LATCH -> DONE -> IDLE.
//   - IDLE: in_ready=0. frame_start=1 -> STREAM with chan=0, byte_cnt=0.
//   - frame_start is ignored in every state except IDLE.
//   - STREAM: in_ready=1 (combinational from state). Accept = in_valid & in_ready.
//   - On accept, at the next edge: mux_data<=in_data; mux_select<=chan; mux_strobe<=1.
//     All three are registered, so latency is 1 clock.
//   - mux_strobe is 0 in any cycle after a non-accept. mux_data and mux_select hold their last values.
//   - Counters on accept: byte_cnt==BYTES_PER_CHANNEL-1 -> byte_cnt=0, chan+1; otherwise byte_cnt+1.
//   - On accept of the last byte of chan 3: go to LATCH, and in_ready drops the next cycle.
//   - Counters wrap to 0 at the same time; no byte is ever accepted beyond the frame.
//   - LATCH: latch=1 for exactly LATCH_CYCLES cycles, in_ready=0. Its first cycle coincides with the final mux_strobe.
//   - DONE: one cycle; frame_done=1, latch=0. Next state IDLE.
//   - A new frame_start is accepted in the cycle after DONE.
//   - Gaps in in_valid simply stall STREAM; byte order and channel order are preserved.
//   - busy=1 in STREAM, LATCH and DONE.
// CONFIGURATION
//   SEQ_UNDERRUN_DETECT_EN defined:
//     - a counter runs in STREAM, cleared on each accept and on entering STREAM.
//     - When UNDERRUN_LIMIT consecutive non-accept cycles are reached: underrun_err pulses 1 cycle, state -> IDLE.
//     - No latch and no frame_done are issued; counters are cleared.
//   SEQ_UNDERRUN_DETECT_EN undefined:
//     - no counter; STREAM waits indefinitely.
//     - underrun_err is tied to 0.
// TESTING
//   All tests use BYTES_PER_CHANNEL=2, LATCH_CYCLES=3.
//   1. Reset mid-STREAM, after 3 bytes accepted:
//      -> all outputs 0 the same cycle; next frame starts at chan 0, byte 0.
//   2. frame_start, in_valid held 1, bytes 0x10..0x17:
//      -> 8 strobes on consecutive cycles.
//      -> select 0,0,1,1,2,2,3,3 with data 0x10..0x17.
//      -> latch high 3 cycles, then frame_done 1 cycle; busy low after that.
//   3. Same frame with in_valid low 5 cycles between bytes 3 and 4:
//      -> identical select/data sequence; no strobe during the gap.
//   4. frame_start pulsed in STREAM and in LATCH:
//      -> ignored; exactly one frame_done is produced.
//   5. Back-to-back: frame_start in the cycle after frame_done:
//      -> second frame starts; first strobe has select=0.
//   6. With SEQ_UNDERRUN_DETECT_EN and UNDERRUN_LIMIT=8: 2 bytes, then in_valid=0:
//      -> underrun_err pulses after the 8th idle cycle; no latch, no frame_done; busy=0.

Source files
------------

// File: rtl/strip_frame_sequencer.sv
// Upstream feeder for the 1-to-4 strip demux: streams one frame per channel 0..3, then latches all strips.
// Optional underrun abort is compiled in when SEQ_UNDERRUN_DETECT_EN is defined.
module strip_frame_sequencer #(
    parameter int IO_WIDTH          = 8,
    parameter int BYTES_PER_CHANNEL = 16,
    parameter int LATCH_CYCLES      = 4,
    parameter int UNDERRUN_LIMIT    = 64
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                frame_start,
    input  logic [IO_WIDTH-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic [1:0]          mux_select,
    output logic [IO_WIDTH-1:0] mux_data,
    output logic                mux_strobe,
    output logic                latch,
    output logic                busy,
    output logic                frame_done,
    output logic                underrun_err
);
    // state    | meaning
    // S_IDLE   | waiting for frame_start
    // S_STREAM | accepting bytes and forwarding them to the demux
    // S_LATCH  | latch pulse to every strip
    // S_DONE   | one-cycle frame_done
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_LATCH, S_DONE} state_t;

    localparam int BW = (BYTES_PER_CHANNEL > 1) ? $clog2(BYTES_PER_CHANNEL) : 1;
    localparam int LW = (LATCH_CYCLES > 1) ? $clog2(LATCH_CYCLES) : 1;
    localparam logic [BW-1:0] BYTE_LAST  = BW'(BYTES_PER_CHANNEL - 1);
    localparam logic [LW-1:0] LATCH_LOAD = LW'(LATCH_CYCLES - 1);

    state_t        state, state_nxt;
    logic [BW-1:0] byte_cnt;
    logic [1:0]    chan;
    logic [LW-1:0] latch_tmr;
    logic          accept;
    logic          last_byte;
    logic          underrun_hit;

    assign in_ready   = (state == S_STREAM);
    assign accept     = in_valid & in_ready;
    assign last_byte  = accept && (chan == 2'd3) && (byte_cnt == BYTE_LAST);
    assign latch      = (state == S_LATCH);
    assign frame_done = (state == S_DONE);
    assign busy       = (state != S_IDLE);

`ifdef SEQ_UNDERRUN_DETECT_EN
    localparam int UW = (UNDERRUN_LIMIT > 1) ? $clog2(UNDERRUN_LIMIT) : 1;
    localparam logic [UW-1:0] IDLE_LOAD = UW'(UNDERRUN_LIMIT - 1);

    logic [UW-1:0] idle_tmr;

    // Timer stays loaded outside STREAM, so it is fresh on entry.
    assign underrun_hit = (state == S_STREAM) && !accept && (idle_tmr == '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            idle_tmr     <= IDLE_LOAD;
            underrun_err <= 1'b0;
        end else begin
            underrun_err <= underrun_hit;
            if ((state != S_STREAM) || accept) begin
                idle_tmr <= IDLE_LOAD;
            end else if (idle_tmr != '0) begin
                idle_tmr <= idle_tmr - UW'(1);
            end
        end
    end
`else
    assign underrun_hit = 1'b0;
    assign underrun_err = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (frame_start) state_nxt = S_STREAM;
            end
            S_STREAM: begin
                if (last_byte) begin
                    state_nxt = S_LATCH;
                end else if (underrun_hit) begin
                    state_nxt = S_IDLE;
                end
            end
            S_LATCH: begin
                if (latch_tmr == '0) state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            byte_cnt   <= '0;
            chan       <= '0;
            latch_tmr  <= '0;
            mux_select <= '0;
            mux_data   <= '0;
            mux_strobe <= 1'b0;
        end else begin
            mux_strobe <= accept;
            if (accept) begin
                mux_data   <= in_data;
                mux_select <= chan;
                // chan wraps 3 -> 0 together with byte_cnt on the final byte
                if (byte_cnt == BYTE_LAST) begin
                    byte_cnt <= '0;
                    chan     <= chan + 2'd1;
                end else begin
                    byte_cnt <= byte_cnt + BW'(1);
                end
            end else if (underrun_hit || ((state == S_IDLE) && frame_start)) begin
                byte_cnt <= '0;
                chan     <= '0;
            end

            if (last_byte) begin
                latch_tmr <= LATCH_LOAD;
            end else if ((state == S_LATCH) && (latch_tmr != '0)) begin
                latch_tmr <= latch_tmr - LW'(1);
            end
        end
    end

endmodule
